// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_pkg
//  Description : Shared opcodes, response codes and FSM state types for the
//                host command link responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmd_pkg;

    // Host command opcodes (first byte of a frame)
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    // Response bytes returned to the host
    localparam logic [7:0] POS_ACK   = 8'hA5;

    // Frame assembly: waiting for opcode, data high byte, data low byte
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_HI = 2'd1,
        GET_LO = 2'd2
    } rx_state_t;

    // Response transmitter: idle, or a byte is on the wire
    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/resp_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : resp_tx_queue
//  Description : Launches response bytes into the UART transmitter. One byte
//                may wait in a pending slot while another is on the wire; a
//                newer request overwrites an unsent pending byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_tx_queue
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       send_resp,
    input  logic [7:0] resp,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent
);

    tx_state_t  r_state;
    logic       r_pend_vld;
    logic [7:0] r_pend_data;
    logic       r_trmt;
    logic [7:0] r_tx_data;
    logic       r_resp_sent;

    // A request arriving with tx_done joins the pending slot first, so the
    // view of the slot used by the tx_done rule already includes it.
    logic       w_pend_vld;
    logic [7:0] w_pend_data;

    assign w_pend_vld  = r_pend_vld | send_resp;
    assign w_pend_data = send_resp ? resp : r_pend_data;

    // Transmit FSM, pending slot and launch/complete pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= TX_IDLE;
            r_pend_vld  <= 1'b0;
            r_pend_data <= 8'h00;
            r_trmt      <= 1'b0;
            r_tx_data   <= 8'h00;
            r_resp_sent <= 1'b0;
        end else begin
            r_trmt      <= 1'b0;
            r_resp_sent <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (send_resp) begin
                        r_tx_data <= resp;
                        r_trmt    <= 1'b1;
                        r_state   <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (tx_done) begin
                        r_resp_sent <= 1'b1;
                        if (w_pend_vld) begin
                            r_tx_data  <= w_pend_data;
                            r_trmt     <= 1'b1;
                            r_pend_vld <= 1'b0;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_pend_vld  <= w_pend_vld;
                        r_pend_data <= w_pend_data;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign trmt      = r_trmt;
    assign tx_data   = r_tx_data;
    assign resp_sent = r_resp_sent;

endmodule
`default_nettype wire

// File: rtl/cmd_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_frame_rx
//  Description : Responder end of the host command link. Assembles 3-byte
//                frames (opcode, data hi, data lo) from the UART receiver,
//                discards partial frames on an inter-byte timeout, and
//                returns response bytes through the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_frame_rx
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int TO_W        = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        clr_cmd_rdy,
    output logic        frame_err,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYC - 1);

    rx_state_t         r_state;
    logic              r_clr_rx_rdy;
    logic              r_frame_err;
    logic [TO_W-1:0]   r_to_cnt;
    logic [7:0]        r_cmd_shadow;
    logic [7:0]        r_data_hi;
    logic              r_cmd_rdy;
    logic [7:0]        r_cmd;
    logic [15:0]       r_data;

    logic              w_accept;
    logic              w_in_frame;
    logic              w_timeout;
    logic              w_frame_start;
    logic              w_frame_done;

    // rx_rdy is still high in the cycle we clear it; that is the same byte,
    // so acceptance is blocked while the clear pulse is out.
    assign w_accept      = rx_rdy & ~r_clr_rx_rdy;
    assign w_in_frame    = (r_state == GET_HI) || (r_state == GET_LO);
    // An arriving byte beats the timeout on the same cycle
    assign w_timeout     = w_in_frame && (r_to_cnt == c_to_last) && !w_accept;
    assign w_frame_start = (r_state == IDLE)   && w_accept;
    assign w_frame_done  = (r_state == GET_LO) && w_accept;

    // Byte-consume and timeout-error pulses, one cycle after the event
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_rx_rdy <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_clr_rx_rdy <= w_accept;
            r_frame_err  <= w_timeout;
        end
    end

    // Inter-byte gap counter: runs only while a frame is partial
    always_ff @(posedge clk) begin
        if (rst || !w_in_frame || w_accept || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Frame assembly FSM; opcode and high byte are held in shadow registers
    // so the visible cmd/data never reflect a partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cmd_shadow <= 8'h00;
            r_data_hi    <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd_shadow <= rx_data;
                        r_state      <= GET_HI;
                    end
                end
                GET_HI: begin
                    if (w_accept) begin
                        r_data_hi <= rx_data;
                        r_state   <= GET_LO;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                GET_LO: begin
                    if (w_accept || w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Published frame and ready flag; completion outranks an acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_rdy <= 1'b0;
            r_cmd     <= 8'h00;
            r_data    <= 16'h0000;
        end else if (w_frame_done) begin
            r_cmd_rdy <= 1'b1;
            r_cmd     <= r_cmd_shadow;
            r_data    <= {r_data_hi, rx_data};
        end else if (clr_cmd_rdy || w_frame_start) begin
            r_cmd_rdy <= 1'b0;
        end
    end

    assign clr_rx_rdy = r_clr_rx_rdy;
    assign frame_err  = r_frame_err;
    assign cmd_rdy    = r_cmd_rdy;
    assign cmd        = r_cmd;
    assign data       = r_data;

    resp_tx_queue u_resp_tx_queue (
        .clk       (clk),
        .rst       (rst),
        .send_resp (send_resp),
        .resp      (resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_sent (resp_sent)
    );

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_frame_rx
//  Description : Self-checking bench for cmd_frame_rx. A behavioural model
//                (byte queue for the partial frame, queue for the pending
//                response) predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_frame_rx;
    import cmd_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        tx_done = 1'b0;
    logic        clr_rx_rdy, cmd_rdy, frame_err, trmt, resp_sent;
    logic [7:0]  cmd, tx_data;
    logic [15:0] data;

    cmd_frame_rx #(.TIMEOUT_CYC(TO), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err),
        .send_resp(send_resp), .resp(resp), .trmt(trmt), .tx_data(tx_data),
        .tx_done(tx_done), .resp_sent(resp_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int clr_cnt = 0;
    int err_cnt = 0;

    // Behavioural model state
    logic [7:0]  mb[$];     // bytes of the partial frame
    int          m_gap;     // cycles spent waiting for the next byte
    logic [7:0]  m_cmd;
    logic [15:0] m_data;
    bit          m_rdy, m_clr, m_err;
    bit          m_busy, m_trmt, m_sent;
    logic [7:0]  m_txd;
    logic [7:0]  mp[$];     // pending response (at most one)

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Predict the outputs visible after the coming clock edge
    task automatic model_step();
        bit acc;
        if (rst) begin
            mb.delete(); mp.delete();
            m_gap = 0; m_cmd = 8'h00; m_data = 16'h0000;
            m_rdy = 0; m_clr = 0; m_err = 0;
            m_busy = 0; m_trmt = 0; m_sent = 0; m_txd = 8'h00;
        end else begin
            acc   = rx_rdy && !m_clr;
            m_clr = acc;
            m_err = 0;
            if (clr_cmd_rdy) m_rdy = 0;
            if (acc) begin
                if (mb.size() == 0) m_rdy = 0;
                mb.push_back(rx_data);
                m_gap = 0;
                if (mb.size() == 3) begin
                    m_cmd  = mb[0];
                    m_data = {mb[1], mb[2]};
                    m_rdy  = 1;
                    mb.delete();
                end
            end else if (mb.size() != 0) begin
                if (m_gap == TO - 1) begin
                    m_err = 1;
                    mb.delete();
                    m_gap = 0;
                end else begin
                    m_gap++;
                end
            end
            m_trmt = 0;
            m_sent = 0;
            if (!m_busy) begin
                if (send_resp) begin
                    m_txd = resp; m_trmt = 1; m_busy = 1;
                end
            end else begin
                if (send_resp) begin
                    mp.delete();
                    mp.push_back(resp);
                end
                if (tx_done) begin
                    m_sent = 1;
                    if (mp.size() != 0) begin
                        m_txd  = mp.pop_front();
                        m_trmt = 1;
                    end else begin
                        m_busy = 0;
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic step(input bit a_rst, input bit a_rr, input logic [7:0] a_rd,
                        input bit a_ccr, input bit a_sr, input logic [7:0] a_rs,
                        input bit a_td);
        @(negedge clk);
        rst = a_rst; rx_rdy = a_rr; rx_data = a_rd; clr_cmd_rdy = a_ccr;
        send_resp = a_sr; resp = a_rs; tx_done = a_td;
        model_step();
        @(posedge clk);
        #1;
        cmp("clr_rx_rdy", {31'd0, clr_rx_rdy}, {31'd0, m_clr});
        cmp("cmd_rdy",    {31'd0, cmd_rdy},    {31'd0, m_rdy});
        cmp("cmd",        {24'd0, cmd},        {24'd0, m_cmd});
        cmp("data",       {16'd0, data},       {16'd0, m_data});
        cmp("frame_err",  {31'd0, frame_err},  {31'd0, m_err});
        cmp("trmt",       {31'd0, trmt},       {31'd0, m_trmt});
        cmp("tx_data",    {24'd0, tx_data},    {24'd0, m_txd});
        cmp("resp_sent",  {31'd0, resp_sent},  {31'd0, m_sent});
        if (clr_rx_rdy === 1'b1) clr_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 8'h00, 0, 0, 8'h00, 0);
    endtask

    task automatic byte_in(input logic [7:0] b);
        step(0, 1, b, 0, 0, 8'h00, 0);
    endtask

    // Three bytes with a gap cycle between them; optional ack on the last
    task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input bit ack_last);
        byte_in(b0); idle(1);
        byte_in(b1); idle(1);
        step(0, 1, b2, ack_last, 0, 8'h00, 0);
    endtask

    initial begin
        int quiet;
        bit rr;

        // Reset state
        step(1, 0, 8'h00, 0, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0, 0, 8'h00, 0);
        cmp("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        cmp("rst_data",    {16'd0, data},    32'd0);
        cmp("rst_tx_data", {24'd0, tx_data}, 32'd0);

        // Basic frame, latency and consume pulses
        clr_cnt = 0;
        frame(SET_PTCH, 8'h00, 8'h01, 0);
        cmp("f1_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        cmp("f1_cmd",     {24'd0, cmd},     32'h02);
        cmp("f1_data",    {16'd0, data},    32'h0001);
        idle(1);
        cmp("f1_clr_cnt", clr_cnt, 32'd3);

        // Acknowledge, then a second frame
        frame(SET_PTCH, 8'h08, 8'h00, 0);
        cmp("f2_data", {16'd0, data}, 32'h0800);
        step(0, 0, 8'h00, 1, 0, 8'h00, 0);
        cmp("f2_ack_rdy", {31'd0, cmd_rdy}, 32'd0);
        frame(SET_PTCH, 8'hFF, 8'hFF, 0);
        cmp("f3_data", {16'd0, data}, 32'hFFFF);
        idle(1);

        // Inter-byte timeout, then recovery
        err_cnt = 0;
        byte_in(SET_PTCH); idle(1);
        byte_in(8'h80);
        idle(TO);
        cmp("to_err_cnt", err_cnt, 32'd1);
        cmp("to_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        idle(2);
        frame(SET_PTCH, 8'h80, 8'h1C, 0);
        cmp("to_data", {16'd0, data}, 32'h801C);
        idle(1);

        // Response path with one pending byte
        step(0, 0, 8'h00, 0, 1, POS_ACK, 0);
        cmp("tx1_trmt", {31'd0, trmt}, 32'd1);
        cmp("tx1_data", {24'd0, tx_data}, 32'hA5);
        step(0, 0, 8'h00, 0, 1, 8'hEE, 0);
        idle(2);
        step(0, 0, 8'h00, 0, 0, 8'h00, 1);
        cmp("tx2_sent", {31'd0, resp_sent}, 32'd1);
        cmp("tx2_trmt", {31'd0, trmt}, 32'd1);
        cmp("tx2_data", {24'd0, tx_data}, 32'hEE);
        idle(2);
        step(0, 0, 8'h00, 0, 0, 8'h00, 1);
        cmp("tx3_sent", {31'd0, resp_sent}, 32'd1);
        cmp("tx3_trmt", {31'd0, trmt}, 32'd0);
        step(0, 0, 8'h00, 0, 1, 8'h3C, 0);
        cmp("tx4_idle_launch", {31'd0, trmt}, 32'd1);
        step(0, 0, 8'h00, 0, 0, 8'h00, 1);

        // Reset mid-frame discards the partial frame
        byte_in(8'h33); idle(1);
        byte_in(8'h44);
        step(1, 0, 8'h00, 0, 0, 8'h00, 0);
        cmp("mrst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        frame(SET_THRST, 8'h00, 8'h40, 0);
        cmp("mrst_cmd",  {24'd0, cmd},  32'h05);
        cmp("mrst_data", {16'd0, data}, 32'h0040);
        idle(1);

        // Acknowledge coincident with completion
        frame(EMER_LAND, 8'h11, 8'h22, 1);
        cmp("coinc_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        cmp("coinc_data", {16'd0, data}, 32'h1122);

        // Randomized traffic on both paths
        quiet = 0;
        for (int i = 0; i < 5000; i++) begin
            if (quiet > 0) begin
                rr = 0;
                quiet--;
            end else begin
                rr = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 40) == 0) quiet = $urandom_range(8, 24);
            end
            step(($urandom_range(0, 499) == 0), rr, 8'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 8'($urandom), (m_busy && ($urandom_range(0, 4) == 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
